pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//   Program-counter controller for the small program counter design. Holds the 6-bit PC and
//   drives an external 6-bit adder instance (sum = a + b, no carry-in/out) to compute
//   PC+STEP or PC+branch offset. Issues a valid/ready fetch handshake and applies
//   halt/jump/branch control each instruction.
// PARAMETERS
//   RESET_PC  6'd0  PC value loaded on reset
//   STEP      6'd1  sequential increment fed to the adder
//   CNT_W     8     width of the retired-fetch counter
// PORTS
//   clk          in   1      clock, all state updates on rising edge
//   rst          in   1      synchronous, active-high reset
//   en           in   1      run enable; sampled in IDLE and UPDATE
//   fetch_ready  in   1      memory accepts the fetch address this cycle
//   fetch_valid  out  1      pc_addr is a valid fetch request
//   pc_addr      out  6      current PC
//   branch_req   in   1      take relative branch (sampled in UPDATE only)
//   branch_off   in   6      two's-complement branch offset
//   jump_req     in   1      take absolute jump (sampled in UPDATE only)
//   jump_addr    in   6      absolute jump target
//   halt_req     in   1      stop after current fetch (sampled in UPDATE only)
//   add_a        out  6      adder operand a (combinational)
//   add_b        out  6      adder operand b (combinational)
//   add_sum      in   6      adder result (combinational, same cycle)
//   state        out  2      FSM state: 0 IDLE, 1 FETCH, 2 UPDATE, 3 HALT
//   halted       out  1      high in HALT
//   fetch_cnt    out  CNT_W  completed fetch handshakes, saturating
// BEHAVIOUR
//   Reset: state=IDLE, pc=RESET_PC, fetch_valid=0, halted=0, fetch_cnt=0. Reset mid-
//     operation (any state, including pending FETCH) takes effect the next edge; no residue.
//   IDLE:   fetch_valid=0. en=1 -> FETCH; else stay.
//   FETCH:  fetch_valid=1, pc_addr=pc. Transfer = fetch_valid & fetch_ready. Transfer ->
//     UPDATE, fetch_cnt+1 (holds at 2^CNT_W-1). No transfer -> stay. fetch_valid never drops
//     before transfer, even if en falls.
//   UPDATE: one cycle; fetch_valid=0. Priority halt_req > jump_req > branch_req > sequential:
//     halt: pc holds, -> HALT. jump: pc<=jump_addr. branch: pc<=add_sum (pc+branch_off).
//     none: pc<=add_sum (pc+STEP). Non-halt next state: en ? FETCH : IDLE.
//   HALT:   fetch_valid=0, halted=1, pc held; exit only by rst.
//   Adder: add_a=pc always; add_b=branch_off when state=UPDATE & branch_req & !jump_req &
//     !halt_req, else STEP. All PC arithmetic is mod 64: wrap and overflow are silent.
//   Throughput: fetch_ready held high -> one fetch per 2 cycles (FETCH, UPDATE).
//   Control inputs outside UPDATE are ignored. halted is registered and asserted in HALT.
// TESTING
//   rst 2 cycles, en=1, ready=1 -> pc_addr 0,1,2,3 on successive fetch_valid pulses every 2 cycles
//   pc=63, sequential UPDATE -> next pc_addr=0 (wrap); fetch_cnt increments normally
//   pc=5, branch_req, branch_off=6'h3E -> next pc_addr=3; branch_off=6'h04 from 62 -> 2
//   UPDATE with jump_req=1, branch_req=1, jump_addr=20 -> next pc_addr=20 (jump wins)
//   ready=0 for 4 cycles in FETCH with en dropped -> fetch_valid and pc_addr stable,
//     transfer on ready -> UPDATE -> IDLE
//   halt_req in UPDATE at pc=9 -> HALT, halted=1, pc stays 9; rst -> IDLE, pc=0, halted=0

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/FETCH/UPDATE/HALT, drives an external 6-bit adder for PC+STEP or PC+offset.
// One fetch per two cycles at full rate; fetch_valid is held until fetch_ready, and PC updates one cycle after transfer.
module pc_sequencer #(
  parameter logic [5:0] RESET_PC = 6'd0,
  parameter logic [5:0] STEP     = 6'd1,
  parameter int         CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [5:0]       pc_addr,
  input  logic             branch_req,
  input  logic [5:0]       branch_off,
  input  logic             jump_req,
  input  logic [5:0]       jump_addr,
  input  logic             halt_req,
  output logic [5:0]       add_a,
  output logic [5:0]       add_b,
  input  logic [5:0]       add_sum,
  output logic [1:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;
  localparam logic [1:0] S_HALT   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [5:0]       pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, halted_d;
  logic             xfer;
  logic             take_branch;

  assign fetch_valid = (state_q == S_FETCH);
  assign xfer        = fetch_valid & fetch_ready;
  assign pc_addr     = pc_q;
  assign state       = state_q;
  assign halted      = halted_q;
  assign fetch_cnt   = cnt_q;

  // The offset only reaches the adder when a branch actually wins arbitration.
  assign take_branch = (state_q == S_UPDATE) & branch_req & ~jump_req & ~halt_req;
  assign add_a       = pc_q;
  assign add_b       = take_branch ? branch_off : STEP;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (xfer) begin
          state_d = S_UPDATE;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_UPDATE: begin
        if (halt_req) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          pc_d    = jump_req ? jump_addr : add_sum;
          state_d = en ? S_FETCH : S_IDLE;
        end
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
    end
  end

endmodule
